// File: rtl/msrv32_fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding imem request, a one-entry skid
// buffer for decode stalls, and discard of stale responses after a redirect.
module msrv32_fetch_ctrl #(
  parameter logic [31:0] RESET_PC          = 32'h0000_0000,
  parameter int unsigned BOOT_FLUSH_CYCLES = 2
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  input  logic        stall_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_gnt_in,
  input  logic        imem_rvalid_in,
  input  logic [31:0] imem_rdata_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid_out,
  output logic        flush_out
);
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [3:0]  BOOT_LAST = 4'(BOOT_FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_t;

  state_t      r_state, w_state_next;
  logic [3:0]  r_boot_cnt, w_boot_cnt_next;
  logic [31:0] r_fetch_pc, w_fetch_pc_next;
  logic [31:0] r_target, w_target_next;
  logic        r_discard, w_discard_next;
  logic [31:0] r_skid_instr, w_skid_instr_next;
  logic [31:0] r_skid_pc, w_skid_pc_next;
  logic [31:0] r_instr, w_instr_next;
  logic [31:0] r_pc, w_pc_next;
  logic        r_valid, w_valid_next;
  logic        w_load;
  logic [31:0] w_load_instr, w_load_pc;

  always_comb begin
    w_state_next      = r_state;
    w_boot_cnt_next   = r_boot_cnt;
    w_fetch_pc_next   = r_fetch_pc;
    w_target_next     = r_target;
    w_discard_next    = r_discard;
    w_skid_instr_next = r_skid_instr;
    w_skid_pc_next    = r_skid_pc;
    w_load            = 1'b0;
    w_load_instr      = imem_rdata_in;
    w_load_pc         = r_fetch_pc;

    case (r_state)
      BOOT: begin
        if (redirect_in) w_fetch_pc_next = redirect_pc_in;
        if (r_boot_cnt == BOOT_LAST) begin
          w_boot_cnt_next = 4'd0;
          w_state_next    = REQ;
        end else begin
          w_boot_cnt_next = r_boot_cnt + 4'd1;
        end
      end
      REQ: begin
        // The address stays put: a redirected request still completes and is dropped later.
        if (redirect_in) begin
          w_discard_next = 1'b1;
          w_target_next  = redirect_pc_in;
        end
        if (imem_gnt_in) w_state_next = WAIT;
      end
      WAIT: begin
        if (imem_rvalid_in) begin
          if (r_discard || redirect_in) begin
            w_discard_next  = 1'b0;
            w_fetch_pc_next = redirect_in ? redirect_pc_in : r_target;
            w_state_next    = REQ;
          end else if (stall_in) begin
            w_skid_instr_next = imem_rdata_in;
            w_skid_pc_next    = r_fetch_pc;
            w_state_next      = HOLD;
          end else begin
            w_load          = 1'b1;
            w_fetch_pc_next = r_fetch_pc + 32'd4;
            w_state_next    = REQ;
          end
        end else if (redirect_in) begin
          w_discard_next = 1'b1;
          w_target_next  = redirect_pc_in;
        end
      end
      HOLD: begin
        if (redirect_in) begin
          w_fetch_pc_next = redirect_pc_in;
          w_state_next    = REQ;
        end else if (!stall_in) begin
          w_load          = 1'b1;
          w_load_instr    = r_skid_instr;
          w_load_pc       = r_skid_pc;
          w_fetch_pc_next = r_fetch_pc + 32'd4;
          w_state_next    = REQ;
        end
      end
      default: w_state_next = BOOT;
    endcase

    // Decode register: redirect beats stall, stall beats a new load.
    w_instr_next = r_instr;
    w_pc_next    = r_pc;
    w_valid_next = r_valid;
    if (redirect_in) begin
      w_valid_next = 1'b0;
      w_instr_next = NOP;
    end else if (!stall_in) begin
      if (w_load) begin
        w_instr_next = w_load_instr;
        w_pc_next    = w_load_pc;
        w_valid_next = 1'b1;
      end else begin
        w_valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      r_state      <= BOOT;
      r_boot_cnt   <= 4'd0;
      r_fetch_pc   <= RESET_PC;
      r_target     <= RESET_PC;
      r_discard    <= 1'b0;
      r_skid_instr <= NOP;
      r_skid_pc    <= RESET_PC;
      r_instr      <= NOP;
      r_pc         <= RESET_PC;
      r_valid      <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_boot_cnt   <= w_boot_cnt_next;
      r_fetch_pc   <= w_fetch_pc_next;
      r_target     <= w_target_next;
      r_discard    <= w_discard_next;
      r_skid_instr <= w_skid_instr_next;
      r_skid_pc    <= w_skid_pc_next;
      r_instr      <= w_instr_next;
      r_pc         <= w_pc_next;
      r_valid      <= w_valid_next;
    end
  end

  assign imem_req_out    = (r_state == REQ);
  assign imem_addr_out   = r_fetch_pc;
  assign instr_out       = r_instr;
  assign pc_out          = r_pc;
  assign instr_valid_out = r_valid;
  assign flush_out       = ~r_valid | redirect_in;
endmodule

// File: tb/tb_msrv32_fetch_ctrl.sv
// Randomized bench for msrv32_fetch_ctrl: a memory/decode driver pushes expected
// (pc, instr) pairs at grant time; a monitor pops them as decode consumes instructions.
module tb_msrv32_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk, rst;
  logic        redirect_in, stall_in, imem_gnt_in, imem_rvalid_in;
  logic [31:0] redirect_pc_in, imem_rdata_in;
  logic        imem_req_out, instr_valid_out, flush_out;
  logic [31:0] imem_addr_out, instr_out, pc_out;

  msrv32_fetch_ctrl dut (
    .ms_riscv32_mp_clk_in(clk),
    .ms_riscv32_mp_rst_in(rst),
    .redirect_in(redirect_in),
    .redirect_pc_in(redirect_pc_in),
    .stall_in(stall_in),
    .imem_req_out(imem_req_out),
    .imem_addr_out(imem_addr_out),
    .imem_gnt_in(imem_gnt_in),
    .imem_rvalid_in(imem_rvalid_in),
    .imem_rdata_in(imem_rdata_in),
    .instr_out(instr_out),
    .pc_out(pc_out),
    .instr_valid_out(instr_valid_out),
    .flush_out(flush_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks, n_pass;
  logic [63:0] exp_q[$];      // {pc, instr} in the order decode must see them
  int          drop_idx, rd_ptr;
  logic        mon_en;
  logic        out_pend, req_redir, prev_req_wait;
  int          pend_cnt;
  logic [31:0] pend_addr, prev_addr, next_exp;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0093;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Decode consumes an instruction when it is valid, not held and not flushed.
  task automatic monitor();
    int rd;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("flush_rule", {31'b0, flush_out}, {31'b0, ~instr_valid_out | redirect_in});
        if (instr_valid_out && !stall_in && !redirect_in) begin
          rd = (rd_ptr < drop_idx) ? drop_idx : rd_ptr;
          check("instr_expected", {31'b0, rd < exp_q.size()}, 32'd1);
          if (rd < exp_q.size()) begin
            check("consume_pc", pc_out, exp_q[rd][63:32]);
            check("consume_instr", instr_out, exp_q[rd][31:0]);
            $display("consume pc=%h instr=%h", pc_out, instr_out);
            rd_ptr = rd + 1;
          end
        end
      end
    end
  endtask

  task automatic reset_model(input logic [31:0] start);
    out_pend      = 1'b0;
    req_redir     = 1'b0;
    prev_req_wait = 1'b0;
    pend_cnt      = 0;
    next_exp      = start;
    drop_idx      = exp_q.size();
  endtask

  // Called at posedge+1: protocol checks, then drives one cycle of random stimulus.
  task automatic drive_cycle();
    logic        g, r;
    logic [31:0] tgt;
    if (out_pend) check("one_outstanding", {31'b0, imem_req_out}, 32'd0);
    if (prev_req_wait) begin
      check("req_held", {31'b0, imem_req_out}, 32'd1);
      check("addr_stable", imem_addr_out, prev_addr);
    end
    r   = ($urandom_range(0, 9) == 0);
    tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF4 : (32'($urandom_range(0, 255)) << 2);
    g   = imem_req_out && ($urandom_range(0, 2) != 0);
    imem_rvalid_in = 1'b0;
    imem_rdata_in  = $urandom;
    if (out_pend) begin
      if (pend_cnt == 1) begin
        imem_rvalid_in = 1'b1;
        imem_rdata_in  = mem_word(pend_addr);
        out_pend       = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    if (imem_req_out && g) begin
      // A request that saw a redirect while issued is stale and never reaches decode.
      if (!(req_redir || r)) begin
        check("fetch_addr", imem_addr_out, next_exp);
        exp_q.push_back({imem_addr_out, mem_word(imem_addr_out)});
        next_exp = imem_addr_out + 32'd4;
      end
      req_redir = 1'b0;
      out_pend  = 1'b1;
      pend_cnt  = $urandom_range(1, 3);
      pend_addr = imem_addr_out;
    end else if (imem_req_out && r) begin
      req_redir = 1'b1;
    end
    if (r) begin
      next_exp = tgt;
      drop_idx = exp_q.size();
    end
    prev_req_wait  = imem_req_out && !g;
    prev_addr      = imem_addr_out;
    imem_gnt_in    = g;
    redirect_in    = r;
    redirect_pc_in = tgt;
    stall_in       = ($urandom_range(0, 3) == 0);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive_cycle();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, {31'b0, imem_req_out}, 32'd0);
    check({tag, "_addr"}, imem_addr_out, RESET_PC);
    check({tag, "_instr"}, instr_out, NOP);
    check({tag, "_pc"}, pc_out, RESET_PC);
    check({tag, "_valid"}, {31'b0, instr_valid_out}, 32'd0);
    check({tag, "_flush"}, {31'b0, flush_out}, 32'd1);
  endtask

  initial begin
    n_checks = 0; n_pass = 0; rd_ptr = 0; drop_idx = 0; mon_en = 1'b0;
    redirect_in = 1'b0; redirect_pc_in = '0; stall_in = 1'b0;
    imem_gnt_in = 1'b0; imem_rvalid_in = 1'b0; imem_rdata_in = '0;
    reset_model(RESET_PC);
    fork monitor(); join_none
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    $display("reset values checked");

    rst = 1'b0;
    #1;
    check("boot0_flush", {31'b0, flush_out}, 32'd1);
    check("boot0_req", {31'b0, imem_req_out}, 32'd0);
    @(posedge clk); #1;
    check("boot1_flush", {31'b0, flush_out}, 32'd1);
    check("boot1_instr", instr_out, NOP);
    check("boot1_req", {31'b0, imem_req_out}, 32'd0);
    @(posedge clk); #1;
    check("first_req", {31'b0, imem_req_out}, 32'd1);
    check("first_addr", imem_addr_out, RESET_PC);
    $display("boot sequence checked");

    mon_en = 1'b1;
    run_cycles(2000);

    // Abort an outstanding fetch with reset; a late response must be ignored.
    for (int i = 0; i < 50 && !out_pend; i++) begin
      drive_cycle();
      @(posedge clk);
      #1;
    end
    check("reach_wait", {31'b0, out_pend}, 32'd1);
    mon_en = 1'b0;
    rst = 1'b1; imem_gnt_in = 1'b0; imem_rvalid_in = 1'b0; redirect_in = 1'b0; stall_in = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0; imem_rvalid_in = 1'b1; imem_rdata_in = 32'hBAD0_0BAD;
    #1;
    check("late_req", {31'b0, imem_req_out}, 32'd0);
    check("late_valid", {31'b0, instr_valid_out}, 32'd0);
    @(posedge clk); #1;
    imem_rvalid_in = 1'b0; redirect_in = 1'b1; redirect_pc_in = 32'h0000_0040;
    #1;
    check("late_ignored_valid", {31'b0, instr_valid_out}, 32'd0);
    check("late_ignored_instr", instr_out, NOP);
    check("boot_redirect_flush", {31'b0, flush_out}, 32'd1);
    check("boot_redirect_req", {31'b0, imem_req_out}, 32'd0);
    @(posedge clk); #1;
    redirect_in = 1'b0;
    check("reboot_req", {31'b0, imem_req_out}, 32'd1);
    check("reboot_addr", imem_addr_out, 32'h0000_0040);
    $display("mid-transaction reset checked");

    reset_model(32'h0000_0040);
    mon_en = 1'b1;
    run_cycles(1500);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/msrv32_fetch_ctrl.md
Name: msrv32_fetch_ctrl

Overview:
Instruction-fetch sequencer for the msrv32 core. It issues requests to instruction memory, tracks the single outstanding request, and buffers one response when decode stalls. It discards stale responses after a redirect. Its outputs feed the instruction mux: the registered instruction, plus a flush that forces a NOP (32'h00000013) whenever no valid instruction is present.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
BOOT_FLUSH_CYCLES, 2, cycles flush_out is held after reset before the first request (range 1-15)

Ports:
ms_riscv32_mp_clk_in  input  1  core clock, rising edge
ms_riscv32_mp_rst_in  input  1  asynchronous, active-high reset
redirect_in  input  1  taken branch/jump/trap this cycle
redirect_pc_in  input  32  redirect target, word aligned
stall_in  input  1  decode hold; decode register must not change
imem_req_out  output  1  fetch request
imem_addr_out  output  32  fetch address
imem_gnt_in  input  1  address accepted when high with req
imem_rvalid_in  input  1  read data valid, one cycle per granted request, earliest one cycle after gnt
imem_rdata_in  input  32  read data
instr_out  output  32  decode instruction, goes to mux ms_riscv32_mp_instr_in
pc_out  output  32  PC of instr_out
instr_valid_out  output  1  instr_out is a real instruction
flush_out  output  1  goes to mux flush_in

Behaviour:
- Reset values (async, while rst high):
  - state=BOOT, boot counter=0
  - fetch_pc=RESET_PC, imem_req_out=0, imem_addr_out=RESET_PC
  - instr_out=32'h00000013, pc_out=RESET_PC, instr_valid_out=0
  - discard=0, skid buffer empty
- flush_out = ~instr_valid_out | redirect_in (combinational).
- imem_addr_out = fetch_pc.
- imem_req_out = 1 only in state REQ (registered state, no combinational path from inputs).
- Bus rule: at most one request outstanding. imem_addr_out must stay stable while req=1 and gnt=0.
- States:
  - BOOT: count BOOT_FLUSH_CYCLES cycles, then go to REQ. A redirect here only loads fetch_pc.
  - REQ: on gnt, go to WAIT. A redirect without gnt sets discard=1 and latches the target; the address does not change. The request completes, and its response is dropped.
  - WAIT: on rvalid there are three cases:
    - discard=1: drop the data, clear discard, fetch_pc=target, go to REQ.
    - stall_in=1: capture rdata and fetch_pc in the skid buffer, go to HOLD.
    - otherwise: load the decode register (instr, pc, valid=1), fetch_pc+=4, go to REQ.
  - HOLD: when stall_in=0, move the skid buffer into the decode register, fetch_pc+=4, go to REQ.
- Decode register update, evaluated every cycle in priority order:
  - (1) redirect_in=1: valid<=0 and instr<=NOP. This overrides stall.
  - (2) stall_in=1: hold the register.
  - (3) a new instruction is loaded from rvalid or the skid buffer.
  - (4) otherwise: valid<=0 (bubble).
- Redirect target handling:
  - The redirect target always wins over +4 sequencing.
  - Several redirects before the stale response returns: the last target wins, and only one response is discarded.
  - Redirect in the same cycle as gnt: that request is marked discard.
  - Redirect in the same cycle as rvalid in WAIT: the response is discarded, and the next state is REQ to redirect_pc_in.
  - Redirect in HOLD: the skid buffer is emptied, fetch_pc=redirect_pc_in, go to REQ.
  - Redirect in REQ when discard is already set: only the target is updated.
- pc arithmetic: 32-bit modulo. fetch_pc+4 wraps from 32'hFFFF_FFFC to 0.
- Protocol errors are ignored: rvalid outside WAIT, and gnt outside REQ.
- Reset mid-transaction returns to BOOT immediately. Any late rvalid for the aborted request is ignored because the FSM is not in WAIT until a new gnt.
- Latency: with a zero-wait memory, gnt is high in REQ and rvalid arrives the cycle after. Sustained throughput is one instruction per 2 cycles, and valid toggles each cycle.

Test Plan:
- Reset, then release: flush_out=1, instr_out=0x00000013 for 2 cycles. Then req=1, addr=0x0. gnt, then rvalid with data 0x00500093: next cycle instr_out=0x00500093, pc_out=0, valid=1, flush_out=0.
- Straight-line: 4 responses without stall -> addresses 0x0, 0x4, 0x8, 0xC in order, each pc_out matches, and valid pulses once per response.
- Stall: hold stall_in=1 while rvalid arrives with 0xDEADBEEF -> decode register unchanged, req=0, state HOLD. Drop stall -> instr_out=0xDEADBEEF, then the next request is at +4.
- Redirect in WAIT to 0x100 -> flush_out=1 that cycle, the pending response is dropped (valid stays 0), and the next request is at addr=0x100.
- Redirect in the same cycle as gnt, with a gnt delayed 3 cycles on the next request -> the first response is discarded. addr to 0x200 is stable through all non-granted cycles.
- Assert reset during WAIT, and rvalid arrives the cycle after release -> it is ignored, outputs are at reset values, and the boot sequence repeats.
